// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: fetch FSM states, instruction size and the
// opcode constants used by the control unit.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DISCARD
   } fetch_state_t;

   localparam int INSTR_BYTES = 4;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; flush wins over push/pop
// and a push is accepted on a full FIFO when a pop happens in the same cycle.
module fetch_fifo #(
   parameter  int width = 64,
   parameter  int depth = 2,
   localparam int ptr_w = $clog2(depth),
   localparam int cnt_w = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [width-1:0] din,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [cnt_w-1:0] count,
   output logic [width-1:0] head
);

   logic [width-1:0] mem [depth];
   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == cnt_w'(depth));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, keeps at most one memory read outstanding and
// buffers returned words for decode; branch redirects flush buffered/in-flight work.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int                     address_width = 32,
   parameter int                     data_width    = 32,
   parameter logic [address_width-1:0] RESET_PC    = '0,
   parameter int                     FIFO_DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req,
   output logic [address_width-1:0] imem_addr,
   input  logic                     imem_rvalid,
   input  logic [data_width-1:0]    imem_rdata,
   output logic                     instr_valid,
   output logic [data_width-1:0]    instr,
   output logic [address_width-1:0] instr_pc,
   input  logic                     instr_ready,
   input  logic                     redirect,
   input  logic [address_width-1:0] redirect_target,
   output logic                     misalign_err
);

   localparam int entry_w = address_width + data_width;
   localparam int cnt_w   = $clog2(FIFO_DEPTH + 1);

   fetch_state_t             state;
   fetch_state_t             state_nxt;
   logic [address_width-1:0] pc;
   logic [address_width-1:0] pc_nxt;
   logic                     push;
   logic                     pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [cnt_w-1:0]         fifo_count_unused;
   logic [entry_w-1:0]       fifo_head;

   fetch_fifo #(
      .width (entry_w),
      .depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({pc, imem_rdata}),
      .pop   (pop),
      .flush (redirect),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count_unused),
      .head  (fifo_head)
   );

   // Head is shown only while valid so idle outputs read as zero.
   assign instr_valid = ~fifo_empty;
   assign instr       = instr_valid ? fifo_head[data_width-1:0] : '0;
   assign instr_pc    = instr_valid ? fifo_head[entry_w-1:data_width] : '0;
   assign pop         = instr_valid & instr_ready;
   assign imem_addr   = imem_req ? pc : '0;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      imem_req  = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE:    state_nxt = ISSUE;
         // fifo_full reflects registered occupancy, so a same-cycle pop never
         // frees the slot a new request relies on.
         ISSUE: begin
            if (!fifo_full) begin
               imem_req  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               push      = 1'b1;
               pc_nxt    = pc + address_width'(INSTR_BYTES);
               state_nxt = ISSUE;
            end
         end
         DISCARD: begin
            if (imem_rvalid) state_nxt = ISSUE;
         end
         default: state_nxt = IDLE;
      endcase

      if (redirect) begin
         push   = 1'b0;
         pc_nxt = {redirect_target[address_width-1:2], 2'b00};
         if ((state == WAIT || state == DISCARD) && imem_rvalid) begin
            state_nxt = ISSUE;
         end else if (state == WAIT || state == DISCARD || imem_req) begin
            state_nxt = DISCARD;
         end else begin
            state_nxt = ISSUE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (redirect && (redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// driven by a variable-latency instruction memory model.
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, req_a, rvalid_a, ivalid_a, ready_a, redir_a, mis_a;
   logic [31:0] addr_a, rdata_a, instr_a, ipc_a, tgt_a;
   logic        rst_b, req_b, rvalid_b, ivalid_b, ready_b, redir_b, mis_b;
   logic [31:0] addr_b, rdata_b, instr_b, ipc_b, tgt_b;

   int n_assert = 0;
   int n_fail   = 0;
   int nreq;

   int          lat     [2];
   bit          pend    [2];
   int          cnt     [2];
   logic [31:0] paddr   [2];
   bit          clr_rst [2];

   instr_fetch_unit dut_a (
      .clk(clk), .rst_n(rst_a), .imem_req(req_a), .imem_addr(addr_a),
      .imem_rvalid(rvalid_a), .imem_rdata(rdata_a), .instr_valid(ivalid_a),
      .instr(instr_a), .instr_pc(ipc_a), .instr_ready(ready_a),
      .redirect(redir_a), .redirect_target(tgt_a), .misalign_err(mis_a)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .rst_n(rst_b), .imem_req(req_b), .imem_addr(addr_b),
      .imem_rvalid(rvalid_b), .imem_rdata(rdata_b), .instr_valid(ivalid_b),
      .instr(instr_b), .instr_pc(ipc_b), .instr_ready(ready_b),
      .redirect(redir_b), .redirect_target(tgt_b), .misalign_err(mis_b)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0)        return 32'h00500093;
      else if (a == 32'h4)   return 32'h00100113;
      else if (a >= 32'h40)  return {a[24:0], OP_BRANCH};
      else                   return {a[24:0], OP_IMM};
   endfunction

   // Memory model: a request seen in cycle N returns in cycle N+lat.
   task automatic mem_step(input int idx, input logic req, input logic [31:0] addr,
                           input logic rst, output logic rv, output logic [31:0] rd);
      rv = 1'b0;
      rd = 32'h0;
      if (pend[idx]) begin
         cnt[idx] = cnt[idx] - 1;
         if (cnt[idx] == 0) begin
            rv        = 1'b1;
            rd        = word_at(paddr[idx]);
            pend[idx] = 1'b0;
         end
      end
      if (!rst && clr_rst[idx]) pend[idx] = 1'b0;
      if (req) begin
         pend[idx]  = 1'b1;
         cnt[idx]   = lat[idx];
         paddr[idx] = addr;
      end
   endtask

   initial begin
      rvalid_a = 1'b0; rdata_a = 32'h0; rvalid_b = 1'b0; rdata_b = 32'h0;
      forever begin
         @(negedge clk);
         mem_step(0, req_a, addr_a, rst_a, rvalid_a, rdata_a);
         mem_step(1, req_b, addr_b, rst_b, rvalid_b, rdata_b);
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Assert reset on dut_a mid-cycle, hold two edges, release: caller is then in cycle 0.
   task automatic reset_a();
      rst_a = 1'b0;
      ticks(2);
      rst_a = 1'b1;
   endtask

   initial begin
      rst_a = 1'b0; ready_a = 1'b1; redir_a = 1'b0; tgt_a = 32'h0;
      rst_b = 1'b0; ready_b = 1'b1; redir_b = 1'b0; tgt_b = 32'h0;
      lat[0] = 1; lat[1] = 1; pend[0] = 1'b0; pend[1] = 1'b0;
      cnt[0] = 0; cnt[1] = 0; paddr[0] = 32'h0; paddr[1] = 32'h0;
      clr_rst[0] = 1'b1; clr_rst[1] = 1'b0;
      ticks(2);
      chk1 ("rst_req",    req_a,    1'b0);
      chk32("rst_addr",   addr_a,   32'h0);
      chk1 ("rst_valid",  ivalid_a, 1'b0);
      chk32("rst_instr",  instr_a,  32'h0);
      chk32("rst_pc",     ipc_a,    32'h0);
      chk1 ("rst_mis",    mis_a,    1'b0);

      // Basic fetch, 1-cycle memory, decode always ready
      rst_a = 1'b1;
      chk1 ("a_c0_req",   req_a,    1'b0);
      tick();
      chk1 ("a_c1_req",   req_a,    1'b1);
      chk32("a_c1_addr",  addr_a,   32'h0);
      tick();
      chk1 ("a_c2_req",   req_a,    1'b0);
      chk1 ("a_c2_valid", ivalid_a, 1'b0);
      tick();
      chk1 ("a_c3_req",   req_a,    1'b1);
      chk32("a_c3_addr",  addr_a,   32'h4);
      chk1 ("a_c3_valid", ivalid_a, 1'b1);
      chk32("a_c3_instr", instr_a,  32'h00500093);
      chk32("a_c3_pc",    ipc_a,    32'h0);
      tick();
      chk1 ("a_c4_valid", ivalid_a, 1'b0);
      tick();
      chk1 ("a_c5_valid", ivalid_a, 1'b1);
      chk32("a_c5_instr", instr_a,  32'h00100113);
      chk32("a_c5_pc",    ipc_a,    32'h4);
      chk32("a_c5_addr",  addr_a,   32'h8);

      // Asynchronous reset mid-operation, then back-pressure for 10 cycles
      rst_a = 1'b0;
      #1;
      chk1 ("mid_rst_req",   req_a,    1'b0);
      chk32("mid_rst_addr",  addr_a,   32'h0);
      chk1 ("mid_rst_valid", ivalid_a, 1'b0);
      chk32("mid_rst_instr", instr_a,  32'h0);
      ready_a = 1'b0;
      tick();
      tick();
      rst_a = 1'b1;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_a) nreq++;
         tick();
      end
      chk32("bp_nreq",    nreq,     32'd2);
      chk1 ("bp_req",     req_a,    1'b0);
      chk1 ("bp_valid",   ivalid_a, 1'b1);
      chk32("bp_instr",   instr_a,  32'h00500093);
      chk32("bp_pc",      ipc_a,    32'h0);
      ready_a = 1'b1;
      tick();
      chk32("drain_instr", instr_a, 32'h00100113);
      chk32("drain_pc",    ipc_a,   32'h4);
      chk1 ("drain_req",   req_a,   1'b1);
      chk32("drain_addr",  addr_a,  32'h8);
      ticks(2);
      chk32("drain_pc8",    ipc_a,   32'h8);
      chk32("drain_instr8", instr_a, word_at(32'h8));

      // Redirect while WAIT with 3-cycle memory: the late 0x8 word must be dropped
      lat[0] = 3;
      reset_a();
      ticks(9);
      chk1 ("c_c9_req",   req_a,  1'b1);
      chk32("c_c9_addr",  addr_a, 32'h8);
      chk32("c_c9_pc",    ipc_a,  32'h4);
      tick();
      redir_a = 1'b1; tgt_a = 32'h40;
      chk1 ("c_c10_req",  req_a,  1'b0);
      tick();
      redir_a = 1'b0;
      chk1 ("c_c11_valid", ivalid_a, 1'b0);
      chk1 ("c_c11_req",   req_a,    1'b0);
      tick();
      chk1 ("c_c12_req",   req_a,    1'b0);
      tick();
      chk1 ("c_c13_req",   req_a,    1'b1);
      chk32("c_c13_addr",  addr_a,   32'h40);
      chk1 ("c_c13_valid", ivalid_a, 1'b0);
      ticks(3);
      chk1 ("c_c16_valid", ivalid_a, 1'b0);
      tick();
      chk1 ("c_c17_valid", ivalid_a, 1'b1);
      chk32("c_c17_pc",    ipc_a,    32'h40);
      chk32("c_c17_instr", instr_a,  word_at(32'h40));

      // Redirect coincident with rvalid, with a buffered word to flush
      lat[0] = 1;
      ready_a = 1'b0;
      reset_a();
      ticks(3);
      chk1 ("d_c3_valid", ivalid_a, 1'b1);
      chk32("d_c3_addr",  addr_a,   32'h4);
      tick();
      redir_a = 1'b1; tgt_a = 32'h80;
      tick();
      redir_a = 1'b0;
      chk1 ("d_c5_valid", ivalid_a, 1'b0);
      chk1 ("d_c5_req",   req_a,    1'b1);
      chk32("d_c5_addr",  addr_a,   32'h80);
      ready_a = 1'b1;
      ticks(2);
      chk1 ("d_c7_valid", ivalid_a, 1'b1);
      chk32("d_c7_pc",    ipc_a,    32'h80);
      chk32("d_c7_instr", instr_a,  word_at(32'h80));

      // Misaligned redirect issued while a request goes out
      reset_a();
      tick();
      chk1 ("e_c1_req",  req_a,  1'b1);
      redir_a = 1'b1; tgt_a = 32'h42;
      tick();
      redir_a = 1'b0;
      chk1 ("e_c2_mis",  mis_a,  1'b1);
      chk1 ("e_c2_req",  req_a,  1'b0);
      tick();
      chk1 ("e_c3_req",  req_a,  1'b1);
      chk32("e_c3_addr", addr_a, 32'h40);
      ticks(2);
      chk32("e_c5_pc",    ipc_a,   32'h40);
      chk32("e_c5_instr", instr_a, word_at(32'h40));
      ticks(3);
      chk1 ("e_c8_mis",  mis_a,  1'b1);

      // Second instance: PC wrap, then reset while WAIT with a response in flight
      rst_b = 1'b1;
      tick();
      chk1 ("b_c1_req",   req_b,  1'b1);
      chk32("b_c1_addr",  addr_b, 32'hFFFF_FFFC);
      ticks(2);
      chk1 ("b_c3_req",   req_b,  1'b1);
      chk32("b_c3_addr",  addr_b, 32'h0);
      chk32("b_c3_pc",    ipc_b,  32'hFFFF_FFFC);
      chk32("b_c3_instr", instr_b, word_at(32'hFFFF_FFFC));
      lat[1] = 3;
      ready_b = 1'b0;
      tick();
      rst_b = 1'b0;
      #1;
      chk1 ("b_rst_req",   req_b,    1'b0);
      chk32("b_rst_addr",  addr_b,   32'h0);
      chk1 ("b_rst_valid", ivalid_b, 1'b0);
      chk32("b_rst_instr", instr_b,  32'h0);
      chk32("b_rst_pc",    ipc_b,    32'h0);
      chk1 ("b_rst_mis",   mis_b,    1'b0);
      ticks(2);
      rst_b = 1'b1;
      ready_b = 1'b1;
      chk1 ("b_n0_req",  req_b,  1'b0);
      tick();
      chk1 ("b_n1_req",  req_b,  1'b1);
      chk32("b_n1_addr", addr_b, 32'hFFFF_FFFC);
      ticks(3);
      chk1 ("b_n4_valid", ivalid_b, 1'b0);
      tick();
      chk1 ("b_n5_valid", ivalid_b, 1'b1);
      chk32("b_n5_pc",    ipc_b,    32'hFFFF_FFFC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
